// File: rtl/sqrt_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_result_fifo
// Purpose  : Captures each result of a square-root core and buffers it in a
//            small show-ahead FIFO. A result is captured once per rising edge
//            of the core's done flag. The core is never stalled. If a result
//            arrives while the FIFO is full and nothing is popped, it is
//            dropped and a sticky overflow flag is set.
// Ports    : clk          - single clock, rising edge
//            rst_n        - asynchronous active-low reset
//            ready_i      - core done flag; a 0->1 edge captures root_i
//            root_i       - core result, valid while ready_i is high
//            out_ready_i  - consumer accepts the head entry
//            out_valid_o  - FIFO holds at least one entry
//            out_data_o   - head entry (show-ahead, combinational)
//            count_o      - current occupancy, 0..DEPTH
//            overflow_o   - sticky: a result was dropped
//            clr_ovf_i    - synchronous clear of overflow_o
// Revision : 1.0 - initial release
// ============================================================================
module sqrt_result_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         ready_i,
   input  logic [DATA_WIDTH-1:0]        root_i,
   input  logic                         out_ready_i,
   output logic                         out_valid_o,
   output logic [DATA_WIDTH-1:0]        out_data_o,
   output logic [$clog2(DEPTH):0]       count_o,
   output logic                         overflow_o,
   input  logic                         clr_ovf_i
);

   localparam int                 c_AW   = $clog2(DEPTH);
   localparam logic [c_AW:0]      c_FULL = DEPTH[c_AW:0];

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]       r_wr_ptr;
   logic [c_AW-1:0]       r_rd_ptr;
   logic [c_AW:0]         r_count;
   logic                  r_ready_d;
   logic                  r_overflow;

   logic                  w_push;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_accept;
   logic                  w_drop;

   // One push per rising edge of the done flag, however long it is held.
   assign w_push   = ready_i & ~r_ready_d;
   // out_valid gates the pop, so popping an empty FIFO cannot happen.
   assign w_pop    = out_valid_o & out_ready_i;
   assign w_full   = (r_count == c_FULL);
   // When full, a push still fits if the head leaves in the same cycle.
   assign w_accept = w_push & (~w_full | w_pop);
   assign w_drop   = w_push & w_full & ~w_pop;

   assign out_valid_o = (r_count != '0);
   assign out_data_o  = r_mem[r_rd_ptr];
   assign count_o     = r_count;
   assign overflow_o  = r_overflow;

   // Edge register resets high so a done flag already asserted when reset
   // releases is not mistaken for a new result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ready_d <= 1'b1;
      end else begin
         r_ready_d <= ready_i;
      end
   end

   // Storage is not reset; contents are meaningless while out_valid_o is low.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_mem[r_wr_ptr] <= root_i;
      end
   end

   // DEPTH is a power of two, so natural pointer wrap gives modulo DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else begin
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // A fresh drop takes priority over a clear in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (clr_ovf_i) begin
         r_overflow <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sqrt_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sqrt_result_fifo
// Purpose  : Directed self-checking bench for sqrt_result_fifo (DEPTH=4,
//            DATA_WIDTH=8): capture, ordering, overflow and clear, full
//            push+pop, pointer wrap and reset behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sqrt_result_fifo;

   logic       clk;
   logic       rst_n;
   logic       ready_i;
   logic [7:0] root_i;
   logic       out_ready_i;
   logic       out_valid_o;
   logic [7:0] out_data_o;
   logic [2:0] count_o;
   logic       overflow_o;
   logic       clr_ovf_i;

   int tests;
   int fails;

   sqrt_result_fifo #(
      .DATA_WIDTH (8),
      .DEPTH      (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ready_i     (ready_i),
      .root_i      (root_i),
      .out_ready_i (out_ready_i),
      .out_valid_o (out_valid_o),
      .out_data_o  (out_data_o),
      .count_o     (count_o),
      .overflow_o  (overflow_o),
      .clr_ovf_i   (clr_ovf_i)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One-cycle done pulse: push lands at the first edge.
   task automatic pulse(input logic [7:0] val);
      ready_i = 1'b1;
      root_i  = val;
      tick();
      ready_i = 1'b0;
      tick();
   endtask

   task automatic expect_empty(input string tag);
      check({tag, "_valid"}, {31'd0, out_valid_o}, 32'd0);
      check({tag, "_count"}, {29'd0, count_o}, 32'd0);
   endtask

   initial begin
      tests       = 0;
      fails       = 0;
      rst_n       = 1'b1;
      ready_i     = 1'b0;
      root_i      = 8'h00;
      out_ready_i = 1'b0;
      clr_ovf_i   = 1'b0;

      // Reset state
      #1 rst_n = 1'b0;
      #1;
      expect_empty("reset");
      check("reset_ovf", {31'd0, overflow_o}, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Single capture with level held high
      ready_i = 1'b1;
      root_i  = 8'h0C;
      tick();
      check("cap_count", {29'd0, count_o}, 32'd1);
      check("cap_data", {24'd0, out_data_o}, 32'h0C);
      check("cap_valid", {31'd0, out_valid_o}, 32'd1);
      repeat (4) tick();
      check("cap_held_count", {29'd0, count_o}, 32'd1);
      ready_i = 1'b0;
      out_ready_i = 1'b1;
      tick();
      expect_empty("cap_drain");
      // out_ready with nothing stored has no effect
      tick();
      expect_empty("empty_ready");
      out_ready_i = 1'b0;

      // Ordering
      pulse(8'h01);
      pulse(8'h02);
      pulse(8'hFF);
      check("ord_count", {29'd0, count_o}, 32'd3);
      out_ready_i = 1'b1;
      check("ord_0", {24'd0, out_data_o}, 32'h01);
      tick();
      check("ord_1", {24'd0, out_data_o}, 32'h02);
      tick();
      check("ord_2", {24'd0, out_data_o}, 32'hFF);
      tick();
      expect_empty("ord_end");
      out_ready_i = 1'b0;

      // Overflow: fifth push is dropped
      pulse(8'h10);
      pulse(8'h11);
      pulse(8'h12);
      pulse(8'h13);
      check("ovf_not_yet", {31'd0, overflow_o}, 32'd0);
      pulse(8'h14);
      check("ovf_flag", {31'd0, overflow_o}, 32'd1);
      check("ovf_count", {29'd0, count_o}, 32'd4);
      out_ready_i = 1'b1;
      check("ovf_d0", {24'd0, out_data_o}, 32'h10);
      tick();
      check("ovf_d1", {24'd0, out_data_o}, 32'h11);
      tick();
      check("ovf_d2", {24'd0, out_data_o}, 32'h12);
      tick();
      check("ovf_d3", {24'd0, out_data_o}, 32'h13);
      tick();
      expect_empty("ovf_end");
      out_ready_i = 1'b0;
      check("ovf_sticky", {31'd0, overflow_o}, 32'd1);
      clr_ovf_i = 1'b1;
      tick();
      clr_ovf_i = 1'b0;
      check("ovf_clr", {31'd0, overflow_o}, 32'd0);

      // Full with simultaneous push and pop
      pulse(8'hA1);
      pulse(8'hA2);
      pulse(8'hA3);
      pulse(8'hA4);
      ready_i     = 1'b1;
      root_i      = 8'h20;
      out_ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
      check("fpp_count", {29'd0, count_o}, 32'd4);
      check("fpp_ovf", {31'd0, overflow_o}, 32'd0);
      check("fpp_d0", {24'd0, out_data_o}, 32'hA2);
      tick();
      check("fpp_d1", {24'd0, out_data_o}, 32'hA3);
      tick();
      check("fpp_d2", {24'd0, out_data_o}, 32'hA4);
      tick();
      check("fpp_d3", {24'd0, out_data_o}, 32'h20);
      tick();
      expect_empty("fpp_end");
      out_ready_i = 1'b0;

      // Overflow coinciding with clear: overflow wins
      pulse(8'h41);
      pulse(8'h42);
      pulse(8'h43);
      pulse(8'h44);
      ready_i   = 1'b1;
      root_i    = 8'h45;
      clr_ovf_i = 1'b1;
      tick();
      ready_i   = 1'b0;
      clr_ovf_i = 1'b0;
      check("ovclr_win", {31'd0, overflow_o}, 32'd1);
      check("ovclr_head", {24'd0, out_data_o}, 32'h41);
      clr_ovf_i = 1'b1;
      tick();
      clr_ovf_i = 1'b0;
      check("ovclr_clear", {31'd0, overflow_o}, 32'd0);
      out_ready_i = 1'b1;
      repeat (4) tick();
      out_ready_i = 1'b0;
      expect_empty("ovclr_end");

      // Wrap-around: 10 push/pop pairs through a 4-entry FIFO
      for (int i = 0; i < 10; i++) begin
         ready_i = 1'b1;
         root_i  = 8'(i);
         tick();
         ready_i = 1'b0;
         check("wrap_data", {24'd0, out_data_o}, 32'(i));
         check("wrap_count", {29'd0, count_o}, 32'd1);
         out_ready_i = 1'b1;
         tick();
         out_ready_i = 1'b0;
      end
      expect_empty("wrap_end");

      // Reset mid-stream with 2 entries held
      pulse(8'h55);
      pulse(8'h66);
      check("rst_pre_count", {29'd0, count_o}, 32'd2);
      #2 rst_n = 1'b0;
      #1;
      expect_empty("rst_async");
      ready_i = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      expect_empty("rst_release_held");
      ready_i = 1'b0;
      tick();
      pulse(8'h33);
      check("rst_new_count", {29'd0, count_o}, 32'd1);
      check("rst_new_data", {24'd0, out_data_o}, 32'h33);
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
      expect_empty("rst_final");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sqrt_result_fifo.md
SQRT_RESULT_FIFO -- requirements
Module: sqrt_result_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning root result width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of FIFO entries; legal values are powers of two, 2 to 16.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port ready_i  input  1  square-root core done flag (core ready_o).
REQ-006 SHALL have port root_i  input  DATA_WIDTH  core result (core root_o), valid while ready_i is high.
REQ-007 SHALL have port out_ready_i  input  1  consumer accepts the head entry.
REQ-008 SHALL have port out_valid_o  output  1  FIFO holds at least one entry.
REQ-009 SHALL have port out_data_o  output  DATA_WIDTH  head entry, show-ahead.
REQ-010 SHALL have port count_o  output  log2(DEPTH)+1  current occupancy.
REQ-011 SHALL have port overflow_o  output  1  sticky flag: a result was dropped.
REQ-012 SHALL have port clr_ovf_i  input  1  synchronous clear of overflow_o.

Function
REQ-013 SHALL keep an edge register ready_d, which loads ready_i every cycle.
REQ-014 SHALL raise push for one cycle when ready_i=1 and ready_d=0; a level held high SHALL produce exactly one push.
REQ-015 SHALL, on push, write root_i to mem[wr_ptr] at that rising edge and advance wr_ptr modulo DEPTH.
REQ-016 SHALL raise pop when out_valid_o=1 and out_ready_i=1; on pop it SHALL advance rd_ptr modulo DEPTH.
REQ-017 SHALL drive out_data_o = mem[rd_ptr] combinationally and out_valid_o = (count_o != 0); no registered output stage.
REQ-018 SHALL have push-to-visibility latency of 1 cycle: a push at edge N gives out_valid_o=1 and the pushed data after edge N.
REQ-019 SHALL update count_o as follows: +1 on push only, -1 on pop only, unchanged on push and pop together or on neither.
REQ-020 SHALL, when full (count_o=DEPTH) with push and no pop, drop the push, leave mem, pointers and count unchanged, and set overflow_o.
REQ-021 SHALL, when full with push and pop in the same cycle, accept both, so count stays DEPTH and no overflow is flagged.
REQ-022 SHALL, when empty with push and out_ready_i=1, treat the cycle as push only (no pop of empty), so count becomes 1.
REQ-023 SHALL treat out_ready_i as having no effect while out_valid_o=0.
REQ-024 SHALL clear overflow_o on clr_ovf_i=1, except that a new overflow in the same cycle wins and overflow_o stays 1.
REQ-025 SHALL hold out_data_o stable while out_valid_o=1 and no pop occurs, even while pushes land in other entries.
REQ-026 SHALL have no stall path back to the core; the core is never back-pressured.

Reset
REQ-027 SHALL, while rst_n=0, force immediately (asynchronously) wr_ptr=0, rd_ptr=0, count_o=0, overflow_o=0 and out_valid_o=0.
REQ-028 SHALL reset ready_d to 1, so a ready_i already high when reset releases causes no push; capture starts at the first genuine 0->1 transition.
REQ-029 SHALL NOT require memory contents to be reset; out_data_o is don't-care while out_valid_o=0.
REQ-030 SHALL, on reset asserted mid-operation, discard all stored entries; the first push after release lands at mem[0].

Verification
REQ-031 SHALL verify single capture. Stimulus: ready_i 0->1 with root_i=8'h0C, held high 5 cycles, out_ready_i=0. Response: count_o=1 after one edge, out_data_o=8'h0C, exactly one entry.
REQ-032 SHALL verify ordering. Stimulus: 3 pulses with roots 8'h01, 8'h02, 8'hFF, then out_ready_i=1. Response: 01, 02, FF on consecutive cycles, then out_valid_o=0 and count_o=0.
REQ-033 SHALL verify overflow with DEPTH=4. Stimulus: 5 pulses (10, 11, 12, 13, 14), no pop. Response: overflow_o=1, count_o=4, drain yields 10..13 only. Then clr_ovf_i=1 for 1 cycle gives overflow_o=0.
REQ-034 SHALL verify full with simultaneous push and pop. Stimulus: full FIFO, a push of 8'h20 in the same cycle as a pop. Response: count_o stays 4, overflow_o stays 0, 8'h20 emerges fourth.
REQ-035 SHALL verify wrap-around. Stimulus: 10 push/pop pairs with values 0..9. Response: outputs 0..9 in order, with pointers wrapping twice.
REQ-036 SHALL verify reset. Stimulus: ready_i=1 across rst_n release, and rst_n pulsed low mid-stream with 2 entries held. Response: no push at release, outputs clear asynchronously, next pulse of 8'h33 is the sole entry.
